// File: rtl/fifo_stream_reader_if.sv
// Handshake bundle between the stream reader, the upstream async FIFO read
// port and the downstream stream consumer. The reader is the master.
interface fifo_stream_reader_if #(
  parameter int BITS     = 32,
  parameter int CNT_BITS = 16
);
  logic                p_flush;
  logic                p_fifo_read_en;
  logic [BITS-1:0]     p_fifo_read_data;
  logic                p_fifo_read_empty;
  logic                p_out_valid;
  logic [BITS-1:0]     p_out_data;
  logic                p_out_ready;
  logic [CNT_BITS-1:0] p_word_count;

  modport master (
    input  p_flush,
    input  p_fifo_read_data,
    input  p_fifo_read_empty,
    input  p_out_ready,
    output p_fifo_read_en,
    output p_out_valid,
    output p_out_data,
    output p_word_count
  );

  modport slave (
    output p_flush,
    output p_fifo_read_data,
    output p_fifo_read_empty,
    output p_out_ready,
    input  p_fifo_read_en,
    input  p_out_valid,
    input  p_out_data,
    input  p_word_count
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Pulls words from an async FIFO read port (one-cycle read latency) into a
// 3-entry in-order skid buffer and presents them as a valid/ready stream.
// The read request depends only on registered occupancy, so downstream
// ready never reaches the FIFO read enable combinationally.
module fifo_stream_reader #(
  parameter int BITS     = 32,
  parameter int CNT_BITS = 16
) (
  input logic                  read_clk,
  input logic                  read_rst,
  fifo_stream_reader_if.master bus
);
  typedef logic [BITS-1:0] word_t;

  word_t               mem_q    [3];
  word_t               mem_next [3];
  logic [1:0]          count_q;
  logic [1:0]          count_next;
  logic [1:0]          wr_idx;
  logic                inflight_q;
  logic                valid_q;
  logic [CNT_BITS-1:0] word_count_q;
  logic [2:0]          occupancy;
  logic                accept;
  logic                push;
  logic                pop;

  // Words held plus the word already requested must leave room for one more.
  assign occupancy = {1'b0, count_q} + {2'b00, inflight_q};
  assign accept    = !bus.p_fifo_read_empty && (occupancy < 3'd3) &&
                     !bus.p_flush && !read_rst;
  assign pop       = valid_q && bus.p_out_ready;
  // A word landing in the flush cycle is dropped.
  assign push      = inflight_q && !bus.p_flush;
  // After a pop the arriving word lands one slot lower.
  assign wr_idx    = count_q - {1'b0, pop};

  assign bus.p_fifo_read_en = accept;
  assign bus.p_out_valid    = valid_q;
  assign bus.p_out_data     = mem_q[0];
  assign bus.p_word_count   = word_count_q;

  // Next buffer contents: shift out the head on a transfer, append arrivals.
  always_comb begin
    mem_next   = mem_q;
    count_next = count_q;
    if (pop) begin
      mem_next[0] = mem_q[1];
      mem_next[1] = mem_q[2];
    end
    if (push && (wr_idx != 2'd3)) begin
      mem_next[wr_idx] = bus.p_fifo_read_data;
    end
    if (bus.p_flush) begin
      count_next = 2'd0;
    end else begin
      count_next = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Control state: occupancy, read-in-flight flag, output valid, word counter.
  always_ff @(posedge read_clk) begin
    if (read_rst) begin
      count_q      <= 2'd0;
      inflight_q   <= 1'b0;
      valid_q      <= 1'b0;
      word_count_q <= '0;
    end else begin
      count_q    <= count_next;
      inflight_q <= accept;
      valid_q    <= (count_next != 2'd0);
      if (pop && !bus.p_flush) begin
        word_count_q <= word_count_q + CNT_BITS'(1);
      end
    end
  end

  // Head slot drives the output word directly, so it has a defined reset value.
  always_ff @(posedge read_clk) begin
    if (read_rst) begin
      mem_q[0] <= '0;
    end else begin
      mem_q[0] <= mem_next[0];
    end
  end

  // Remaining slots are plain data storage, qualified by count_q.
  always_ff @(posedge read_clk) begin
    mem_q[1] <= mem_next[1];
    mem_q[2] <= mem_next[2];
  end

  // Read gating must make a fourth buffered word impossible.
  buffer_no_overflow: assert property (
    @(posedge read_clk) disable iff (read_rst)
      !((count_q == 2'd3) && push && !pop)
  );
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioral upstream FIFO, scoreboard of words
// loaded into it, and a word-count model stepped on every observed handshake.
module tb_fifo_stream_reader;
  localparam int BITS     = 16;
  localparam int CNT_BITS = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_stream_reader_if #(.BITS(BITS), .CNT_BITS(CNT_BITS)) bus ();

  fifo_stream_reader #(.BITS(BITS), .CNT_BITS(CNT_BITS)) dut (
    .read_clk (clk),
    .read_rst (rst),
    .bus      (bus)
  );

  logic [BITS-1:0]     fifo_q [$];
  logic [BITS-1:0]     exp_q  [$];
  logic [CNT_BITS-1:0] exp_cnt;
  logic [BITS-1:0]     next_word;
  logic [BITS-1:0]     data_prev;
  logic                stall_prev;
  logic                last_rd;
  logic [CNT_BITS-1:0] cnt_before;
  int tests = 0;
  int fails = 0;
  int cyc, rd_cnt, hs_cnt, first_rd, first_vld, hs_first, hs_last;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(next_word);
      exp_q.push_back(next_word);
      next_word = next_word + 16'd1;
    end
    bus.p_fifo_read_empty = (fifo_q.size() == 0);
  endtask

  task automatic reset_track();
    cyc = 0; rd_cnt = 0; hs_cnt = 0;
    first_rd = -1; first_vld = -1; hs_first = -1; hs_last = -1;
  endtask

  // One clock cycle: sample DUT before the edge, model FIFO and scoreboard after.
  task automatic tick();
    logic rd, hs, rs, fl, vld;
    logic [BITS-1:0] dat;
    #1;
    rd  = bus.p_fifo_read_en;
    vld = bus.p_out_valid;
    dat = bus.p_out_data;
    hs  = vld && bus.p_out_ready;
    rs  = rst;
    fl  = bus.p_flush;
    if (rs || fl) check_eq("rd_en_blocked", 32'(rd), 32'd0);
    if (stall_prev) begin
      check_eq("stall_valid", 32'(vld), 32'd1);
      check_eq("stall_data", 32'(dat), 32'(data_prev));
    end
    if (rd && first_rd < 0) first_rd = cyc;
    if (vld && !rs && first_vld < 0) first_vld = cyc;
    if (hs && !rs && !fl) begin
      check_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check_eq("out_data", 32'(dat), 32'(exp_q.pop_front()));
      exp_cnt = exp_cnt + 4'd1;
      hs_cnt++;
      if (hs_first < 0) hs_first = cyc;
      hs_last = cyc;
    end
    stall_prev = vld && !bus.p_out_ready && !rs && !fl;
    data_prev  = dat;
    last_rd    = rd;
    if (rd) rd_cnt++;
    @(posedge clk);
    #1;
    cyc++;
    if (rd) bus.p_fifo_read_data = fifo_q.pop_front();
    else    bus.p_fifo_read_data = BITS'($urandom);
    if (rs) exp_cnt = '0;
    if (rs || fl) begin
      exp_q = fifo_q;
      stall_prev = 1'b0;
    end
    bus.p_fifo_read_empty = (fifo_q.size() == 0);
    check_eq("word_count", 32'(bus.p_word_count), 32'(exp_cnt));
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    check_eq("drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.p_flush = 1'b0;
    bus.p_out_ready = 1'b0;
    bus.p_fifo_read_data = '0;
    bus.p_fifo_read_empty = 1'b1;
    exp_cnt = '0;
    next_word = 16'h0A00;
    stall_prev = 1'b0;
    data_prev = '0;
    last_rd = 1'b0;
    reset_track();

    // Reset with a non-empty FIFO: nothing may be requested or presented.
    load(5);
    repeat (3) tick();
    #1;
    check_eq("rst_rd_en", 32'(bus.p_fifo_read_en), 32'd0);
    check_eq("rst_valid", 32'(bus.p_out_valid), 32'd0);
    check_eq("rst_data", 32'(bus.p_out_data), 32'd0);
    check_eq("rst_wcnt", 32'(bus.p_word_count), 32'd0);

    // Five words streamed with ready held high.
    rst = 1'b0;
    bus.p_out_ready = 1'b1;
    reset_track();
    #1;
    check_eq("first_rd_after_rst", 32'(bus.p_fifo_read_en), 32'd1);
    drain(40);
    check_eq("valid_latency", 32'(first_vld - first_rd), 32'd2);
    check_eq("back_to_back", 32'(hs_last - hs_first), 32'd4);
    check_eq("wcnt5", 32'(bus.p_word_count), 32'd5);

    // Six words with ready low: buffer fills to three, then holds.
    bus.p_out_ready = 1'b0;
    reset_track();
    load(6);
    repeat (8) tick();
    check_eq("reads_when_full", 32'(rd_cnt), 32'd3);
    #1;
    check_eq("rd_en_full", 32'(bus.p_fifo_read_en), 32'd0);
    check_eq("hold_valid", 32'(bus.p_out_valid), 32'd1);
    check_eq("hold_head", 32'(bus.p_out_data), 32'(exp_q[0]));
    bus.p_out_ready = 1'b1;
    drain(40);
    check_eq("six_words", 32'(hs_cnt), 32'd6);

    // Twenty words with ready toggling every cycle.
    reset_track();
    load(20);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
      bus.p_out_ready = (i % 2 == 0);
      tick();
    end
    check_eq("toggle_drained", 32'(exp_q.size()), 32'd0);
    check_eq("toggle_words", 32'(hs_cnt), 32'd20);

    // Flush with two words buffered and a third in flight.
    bus.p_out_ready = 1'b0;
    reset_track();
    load(5);
    for (int i = 0; i < 20 && rd_cnt < 3; i++) tick();
    check_eq("flush_setup", 32'(rd_cnt), 32'd3);
    cnt_before = exp_cnt;
    bus.p_out_ready = 1'b1;
    bus.p_flush = 1'b1;
    tick();
    bus.p_flush = 1'b0;
    #1;
    check_eq("flush_valid", 32'(bus.p_out_valid), 32'd0);
    check_eq("flush_wcnt", 32'(bus.p_word_count), 32'(cnt_before));
    reset_track();
    drain(40);
    check_eq("post_flush_words", 32'(hs_cnt), 32'd2);

    // Counter wrap: 17 transfers on a 4-bit counter.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    reset_track();
    load(17);
    drain(80);
    check_eq("wcnt_wrap", 32'(bus.p_word_count), 32'd1);

    // Reset mid-stream while a read is in flight.
    load(10);
    repeat (4) tick();
    check_eq("inflight_before_rst", 32'(last_rd), 32'd1);
    rst = 1'b1;
    tick();
    #1;
    check_eq("midrst_rd_en", 32'(bus.p_fifo_read_en), 32'd0);
    check_eq("midrst_valid", 32'(bus.p_out_valid), 32'd0);
    check_eq("midrst_data", 32'(bus.p_out_data), 32'd0);
    check_eq("midrst_wcnt", 32'(bus.p_word_count), 32'd0);
    rst = 1'b0;
    drain(60);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end
endmodule
